// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply and
// restoring divide on a shared 64-bit register, plus single-cycle MTHI/MTLO.
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    opnd;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;

  logic            accept_c;
  logic            arith_c;
  logic            eff_sgn_c;
  logic [W-1:0]    a_mag_c;
  logic [W-1:0]    b_mag_c;
  logic [W:0]      mul_sum_c;
  logic [2*W-1:0]  mul_next_c;
  logic [W:0]      rem_sh_c;
  logic            div_ge_c;
  logic [W:0]      rem_nx_c;
  logic [2*W-1:0]  div_next_c;
  logic [2*W-1:0]  mul_fix_c;
  logic [W-1:0]    quo_fix_c;
  logic [W-1:0]    rem_fix_c;

  assign busy = (state_q != IDLE);

  // Operand conditioning; divide-by-zero runs unsigned so HI ends up as the raw dividend
  always_comb begin
    accept_c  = start && (state_q == IDLE);
    arith_c   = accept_c && !op[2];
    eff_sgn_c = !op[0] && !(op[1] && (b == '0));
    a_mag_c   = (eff_sgn_c && a[W-1]) ? W'(-a) : a;
    b_mag_c   = (eff_sgn_c && b[W-1]) ? W'(-b) : b;
  end

  // One iteration step for each operation, plus the final sign correction
  always_comb begin
    mul_sum_c  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : (W+1)'(0));
    mul_next_c = {mul_sum_c, prod[W-1:1]};
    rem_sh_c   = {prod[2*W-1:W], prod[W-1]};
    div_ge_c   = (rem_sh_c >= {1'b0, opnd});
    rem_nx_c   = div_ge_c ? (rem_sh_c - {1'b0, opnd}) : rem_sh_c;
    div_next_c = {rem_nx_c[W-1:0], prod[W-2:0], div_ge_c};
    mul_fix_c  = neg_q ? (2*W)'(-prod) : prod;
    quo_fix_c  = neg_q ? W'(-prod[W-1:0]) : prod[W-1:0];
    rem_fix_c  = neg_r ? W'(-prod[2*W-1:W]) : prod[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arith_c) state_d = RUN;
      RUN:     if (cnt == CW'(W - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      prod   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arith_c) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= eff_sgn_c && (a[W-1] ^ b[W-1]);
            neg_r  <= eff_sgn_c && a[W-1];
            if (op[1]) begin
              prod <= {W'(0), a_mag_c};
              opnd <= b_mag_c;
            end else begin
              prod <= {W'(0), b_mag_c};
              opnd <= a_mag_c;
            end
          end else if (accept_c && (op == OP_MTHI)) begin
            hi <= a;
          end else if (accept_c && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        RUN: begin
          cnt  <= cnt + CW'(1);
          prod <= is_div ? div_next_c : mul_next_c;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix_c;
            lo <= quo_fix_c;
          end else begin
            hi <= mul_fix_c[2*W-1:W];
            lo <= mul_fix_c[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO queued at issue time,
// popped and compared by a monitor whenever busy falls.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  bit          abort_pending = 0;
  bit          busy_prev = 0;
  int          busy_cycles = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mips_muldiv_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Architectural result {hi, lo} of a MULT/MULTU/DIV/DIVU from plain arithmetic
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, q, r;
    logic [63:0] p, vq, vr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    p  = '0;
    case (o)
      3'd0: p = 64'(sx * sy);
      3'd1: p = 64'(ux * uy);
      default: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF};
        end else begin
          if (o == 3'd2) begin q = sx / sy; r = sx % sy; end
          else           begin q = ux / uy; r = ux % uy; end
          vq = 64'(q);
          vr = 64'(r);
          p  = {vr[31:0], vq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Monitor: every falling edge of busy delivers one result to the scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (busy) begin
      busy_cycles++;
    end else if (busy_prev) begin
      if (abort_pending) begin
        abort_pending = 0;
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual hi=%h lo=%h expected no result", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", hi, e[63:32]);
        check("result_lo", lo, e[31:0]);
        check("latency", 32'(busy_cycles), 32'd33);
      end
      busy_cycles = 0;
    end
    busy_prev = busy;
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit stray, input logic [31:0] stray_a);
    logic [63:0] e;
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    e = ref_op(o, av, bv);
    if (!o[2]) exp_q.push_back(e);
    else if (o == 3'b100) m_hi = av;
    else if (o == 3'b101) m_lo = av;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    if (!o[2]) begin
      n = 0;
      while (busy && n < 100) begin
        if (stray && n == 4) begin
          start = 1'b1; op = 3'b101; a = stray_a;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout actual busy=%b after %0d cycles expected busy=0", busy, n);
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end else begin
      check("mt_busy", 32'(busy), 32'd0);
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, '0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, '0);
    run_op(3'd3, 32'd100, 32'd0, 0, '0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0);
    run_op(3'd4, 32'h1234_5678, 32'd0, 0, '0);
    run_op(3'd1, 32'd3, 32'd5, 1, 32'h0000_DEAD);
    check("after_ignored_mtlo_hi", hi, 32'd0);
    check("after_ignored_mtlo_lo", lo, 32'h0000_000F);
    run_op(3'd2, 32'd17, 32'd0, 0, '0);
    run_op(3'd6, 32'hCAFE_F00D, 32'd1, 0, '0);

    // Reset mid-operation discards the divide and clears HI/LO
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    abort_pending = 1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    run_op(3'd3, 32'd1000, 32'd7, 0, '0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), $urandom);
    end

    repeat (2) @(negedge clk);
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
